// File: rtl/bm_wrr_output_arbiter.sv
// bm_wrr_output_arbiter: weighted round-robin owner select for one
// bus-matrix slave port shared by four input ports.
module bm_wrr_output_arbiter #(
  parameter int WEIGHT_W = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [3:0]          req_port,
  input  logic [WEIGHT_W-1:0] cfg_weight0,
  input  logic [WEIGHT_W-1:0] cfg_weight1,
  input  logic [WEIGHT_W-1:0] cfg_weight2,
  input  logic [WEIGHT_W-1:0] cfg_weight3,
  input  logic                HREADYM,
  input  logic                HSELM,
  input  logic [1:0]          HTRANSM,
  input  logic [2:0]          HBURSTM,
  input  logic                HMASTLOCKM,
  output logic [1:0]          addr_in_port,
  output logic                no_port,
  output logic [WEIGHT_W-1:0] credit_remain
);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  localparam logic [WEIGHT_W-1:0] W_ONE  = WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] W_ZERO = '0;

  logic [3:0]          burst_remain;
  logic                burst_hold;
  logic [3:0]          nxt_remain;
  logic                nxt_hold;

  logic [WEIGHT_W-1:0] weight [4];
  logic                xfer;
  logic [WEIGHT_W-1:0] credit_dec;
  logic                keep_ok;

  logic                low_found;
  logic [1:0]          low_idx;
  logic                rr_found;
  logic [1:0]          rr_idx;
  logic [1:0]          cand;

  logic [1:0]          nxt_addr;
  logic                nxt_no_port;
  logic [WEIGHT_W-1:0] nxt_credit;

  // A zero quota would starve the owner, so it counts as one.
  always_comb begin
    weight[0] = (cfg_weight0 == W_ZERO) ? W_ONE : cfg_weight0;
    weight[1] = (cfg_weight1 == W_ZERO) ? W_ONE : cfg_weight1;
    weight[2] = (cfg_weight2 == W_ZERO) ? W_ONE : cfg_weight2;
    weight[3] = (cfg_weight3 == W_ZERO) ? W_ONE : cfg_weight3;
  end

  always_comb begin
    nxt_remain = 4'd0;
    nxt_hold   = 1'b0;
    if (HSELM) begin
      unique case (HTRANSM)
        T_IDLE: begin
          nxt_remain = 4'd0;
          nxt_hold   = 1'b0;
        end
        T_BUSY: begin
          nxt_remain = burst_remain;
          nxt_hold   = burst_hold;
        end
        T_NSEQ: begin
          unique case (HBURSTM)
            3'b010, 3'b011: nxt_remain = 4'd3;
            3'b100, 3'b101: nxt_remain = 4'd7;
            3'b110, 3'b111: nxt_remain = 4'd15;
            default:        nxt_remain = 4'd0;
          endcase
          nxt_hold = (nxt_remain != 4'd0);
        end
        T_SEQ: begin
          nxt_remain = (burst_remain != 4'd0) ?
                       burst_remain - 4'd1 : 4'd0;
          nxt_hold   = (nxt_remain != 4'd0);
        end
        default: begin
          nxt_remain = 4'd0;
          nxt_hold   = 1'b0;
        end
      endcase
    end
  end

  assign xfer       = HSELM & HTRANSM[1];
  assign credit_dec = (xfer && credit_remain != W_ZERO) ?
                      credit_remain - W_ONE : credit_remain;
  assign keep_ok    = req_port[addr_in_port] | HSELM;

  always_comb begin
    low_found = 1'b0;
    low_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_port[i]) begin
        low_found = 1'b1;
        low_idx   = 2'(i);
      end
    end
  end

  // Walk backwards so the nearest port after the owner wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = addr_in_port;
    cand     = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = addr_in_port + 2'(k);
      if (req_port[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    nxt_addr    = addr_in_port;
    nxt_no_port = no_port;
    nxt_credit  = credit_dec;
    if (HMASTLOCKM || nxt_hold) begin
      nxt_credit = credit_dec;
    end else if (no_port) begin
      if (low_found) begin
        nxt_addr    = low_idx;
        nxt_no_port = 1'b0;
        nxt_credit  = weight[low_idx];
      end else begin
        nxt_credit  = W_ZERO;
      end
    end else if (credit_dec != W_ZERO && keep_ok) begin
      nxt_credit = credit_dec;
    end else if (rr_found) begin
      nxt_addr   = rr_idx;
      nxt_credit = weight[rr_idx];
    end else if (keep_ok) begin
      nxt_credit = weight[addr_in_port];
    end else begin
      nxt_no_port = 1'b1;
      nxt_credit  = W_ZERO;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port  <= 2'd0;
      no_port       <= 1'b1;
      credit_remain <= W_ZERO;
      burst_remain  <= 4'd0;
      burst_hold    <= 1'b0;
    end else if (HREADYM) begin
      addr_in_port  <= nxt_addr;
      no_port       <= nxt_no_port;
      credit_remain <= nxt_credit;
      burst_remain  <= nxt_remain;
      burst_hold    <= nxt_hold;
    end
  end

endmodule

// File: tb/tb_bm_wrr_output_arbiter.sv
// Directed bench for bm_wrr_output_arbiter: grant order, quotas,
// burst/lock hold, ready stalls and async reset.
module tb_bm_wrr_output_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] req_port;
  logic [3:0] cfg_weight0;
  logic [3:0] cfg_weight1;
  logic [3:0] cfg_weight2;
  logic [3:0] cfg_weight3;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [3:0] credit_remain;

  int tests_run;
  int tests_failed;

  bm_wrr_output_arbiter #(.WEIGHT_W(4)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .req_port      (req_port),
    .cfg_weight0   (cfg_weight0),
    .cfg_weight1   (cfg_weight1),
    .cfg_weight2   (cfg_weight2),
    .cfg_weight3   (cfg_weight3),
    .HREADYM       (HREADYM),
    .HSELM         (HSELM),
    .HTRANSM       (HTRANSM),
    .HBURSTM       (HBURSTM),
    .HMASTLOCKM    (HMASTLOCKM),
    .addr_in_port  (addr_in_port),
    .no_port       (no_port),
    .credit_remain (credit_remain)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSELM      = 1'b0;
    HTRANSM    = IDLE;
    HBURSTM    = 3'b000;
    HMASTLOCKM = 1'b0;
    HREADYM    = 1'b1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_bus();
    req_port = 4'b1111;
    cfg_weight0 = 4'd3; cfg_weight1 = 4'd1;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    tests_run++;
    if (no_port !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_no_port: got %0b want 1", no_port);
    end
    tests_run++;
    if (addr_in_port !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_addr: got %0d want 0", addr_in_port);
    end
    tests_run++;
    if (credit_remain !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_credit: got %0d want 0", credit_remain);
    end
    HRESETn = 1'b1;
    step();
    tests_run++;
    if (addr_in_port !== 2'd0 || no_port !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_grant: got addr=%0d np=%0b want 0/0",
               addr_in_port, no_port);
    end
    tests_run++;
    if (credit_remain !== 4'd3) begin
      tests_failed++;
      $display("FAIL first_credit: got %0d want 3", credit_remain);
    end
  endtask

  task automatic test_wrr();
    int ea [6] = '{0, 0, 1, 0, 0, 1};
    int ec [6] = '{2, 1, 1, 2, 1, 1};
    idle_bus();
    req_port = 4'b0011;
    cfg_weight0 = 4'd2; cfg_weight1 = 4'd1;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    HSELM = 1'b1; HTRANSM = NSEQ; HBURSTM = 3'b000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (addr_in_port !== 2'(ea[i]) || credit_remain !== 4'(ec[i])) begin
        tests_failed++;
        $display("FAIL wrr[%0d]: got addr=%0d cr=%0d want %0d/%0d",
                 i, addr_in_port, credit_remain, ea[i], ec[i]);
      end
    end
    idle_bus();
  endtask

  task automatic test_burst();
    logic [1:0] tr [9] = '{NSEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
    idle_bus();
    req_port = 4'b0100;
    cfg_weight0 = 4'd1; cfg_weight1 = 4'd1;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    do_reset();
    step();
    tests_run++;
    if (addr_in_port !== 2'd2 || credit_remain !== 4'd1) begin
      tests_failed++;
      $display("FAIL burst_grant: got addr=%0d cr=%0d want 2/1",
               addr_in_port, credit_remain);
    end
    req_port = 4'b1100;
    HSELM = 1'b1; HBURSTM = 3'b101;
    for (int i = 0; i < 9; i++) begin
      HTRANSM = tr[i];
      step();
      if (i < 8) begin
        tests_run++;
        if (addr_in_port !== 2'd2) begin
          tests_failed++;
          $display("FAIL burst_hold[%0d]: got %0d want 2", i, addr_in_port);
        end
      end else begin
        tests_run++;
        if (addr_in_port !== 2'd3 || credit_remain !== 4'd1) begin
          tests_failed++;
          $display("FAIL burst_end: got addr=%0d cr=%0d want 3/1",
                   addr_in_port, credit_remain);
        end
      end
    end
    idle_bus();
  endtask

  task automatic test_lock();
    int ec [6] = '{1, 0, 0, 0, 0, 0};
    idle_bus();
    req_port = 4'b0010;
    cfg_weight0 = 4'd1; cfg_weight1 = 4'd2;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    do_reset();
    step();
    req_port = 4'b0011;
    HSELM = 1'b1; HTRANSM = NSEQ; HBURSTM = 3'b000; HMASTLOCKM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (addr_in_port !== 2'd1 || credit_remain !== 4'(ec[i])) begin
        tests_failed++;
        $display("FAIL lock[%0d]: got addr=%0d cr=%0d want 1/%0d",
                 i, addr_in_port, credit_remain, ec[i]);
      end
    end
    HMASTLOCKM = 1'b0;
    step();
    tests_run++;
    if (addr_in_port !== 2'd0 || credit_remain !== 4'd1) begin
      tests_failed++;
      $display("FAIL lock_release: got addr=%0d cr=%0d want 0/1",
               addr_in_port, credit_remain);
    end
    idle_bus();
  endtask

  task automatic test_ready_stall();
    idle_bus();
    req_port = 4'b0001;
    cfg_weight0 = 4'd1; cfg_weight1 = 4'd1;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    do_reset();
    step();
    HREADYM = 1'b0;
    req_port = 4'b1000;
    HSELM = 1'b1; HTRANSM = NSEQ;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (addr_in_port !== 2'd0 || no_port !== 1'b0 ||
          credit_remain !== 4'd1) begin
        tests_failed++;
        $display("FAIL stall[%0d]: got addr=%0d np=%0b cr=%0d want 0/0/1",
                 i, addr_in_port, no_port, credit_remain);
      end
    end
    HREADYM = 1'b1;
    step();
    tests_run++;
    if (addr_in_port !== 2'd3 || credit_remain !== 4'd1) begin
      tests_failed++;
      $display("FAIL stall_release: got addr=%0d cr=%0d want 3/1",
               addr_in_port, credit_remain);
    end
  endtask

  task automatic test_release();
    idle_bus();
    req_port = 4'b0000;
    step();
    tests_run++;
    if (no_port !== 1'b1 || addr_in_port !== 2'd3 ||
        credit_remain !== 4'd0) begin
      tests_failed++;
      $display("FAIL release: got np=%0b addr=%0d cr=%0d want 1/3/0",
               no_port, addr_in_port, credit_remain);
    end
    req_port = 4'b0110;
    step();
    tests_run++;
    if (no_port !== 1'b0 || addr_in_port !== 2'd1) begin
      tests_failed++;
      $display("FAIL regrant: got np=%0b addr=%0d want 0/1",
               no_port, addr_in_port);
    end
  endtask

  task automatic test_zero_weight();
    idle_bus();
    req_port = 4'b0001;
    cfg_weight0 = 4'd0; cfg_weight1 = 4'd0;
    cfg_weight2 = 4'd0; cfg_weight3 = 4'd0;
    HSELM = 1'b1; HTRANSM = NSEQ;
    do_reset();
    step();
    tests_run++;
    if (credit_remain !== 4'd1) begin
      tests_failed++;
      $display("FAIL zero_weight: got %0d want 1", credit_remain);
    end
    cfg_weight0 = 4'd5;
    step();
    tests_run++;
    if (addr_in_port !== 2'd0 || credit_remain !== 4'd5) begin
      tests_failed++;
      $display("FAIL reload: got addr=%0d cr=%0d want 0/5",
               addr_in_port, credit_remain);
    end
    cfg_weight0 = 4'd2;
    step();
    tests_run++;
    if (credit_remain !== 4'd4) begin
      tests_failed++;
      $display("FAIL mid_tenure_cfg: got %0d want 4", credit_remain);
    end
    idle_bus();
  endtask

  task automatic test_async_reset();
    idle_bus();
    req_port = 4'b0001;
    cfg_weight0 = 4'd3; cfg_weight1 = 4'd1;
    cfg_weight2 = 4'd1; cfg_weight3 = 4'd1;
    do_reset();
    step();
    HSELM = 1'b1; HTRANSM = NSEQ; HBURSTM = 3'b011;
    step();
    HTRANSM = SEQ;
    #2;
    HRESETn = 1'b0;
    #1;
    tests_run++;
    if (no_port !== 1'b1 || addr_in_port !== 2'd0 ||
        credit_remain !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_rst: got np=%0b addr=%0d cr=%0d want 1/0/0",
               no_port, addr_in_port, credit_remain);
    end
    idle_bus();
    req_port = 4'b0100;
    HRESETn = 1'b1;
    step();
    tests_run++;
    if (no_port !== 1'b0 || addr_in_port !== 2'd2 ||
        credit_remain !== 4'd1) begin
      tests_failed++;
      $display("FAIL post_rst_grant: got np=%0b addr=%0d cr=%0d want 0/2/1",
               no_port, addr_in_port, credit_remain);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    HRESETn      = 1'b0;
    req_port     = 4'b0000;
    cfg_weight0  = 4'd1;
    cfg_weight1  = 4'd1;
    cfg_weight2  = 4'd1;
    cfg_weight3  = 4'd1;
    idle_bus();
    test_reset();
    test_wrr();
    test_burst();
    test_lock();
    test_ready_stall();
    test_release();
    test_zero_weight();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
